// File: rtl/alu_op_issue_pkg.sv
// Shared definitions for the ALU op issue stage.
//   alu_sel_e      : ALU operation select encoding
//   Op* / Fn*      : opcode and R-type funct constants understood by the decoder
//   CntWidth       : width of the issued-op counter
//   issue_state_e  : EMPTY/FULL occupancy of the single register stage
//   sext16/zext16  : immediate extension helpers
package alu_op_issue_pkg;

  typedef enum logic [2:0] {
    SelAdd  = 3'b000,
    SelSub  = 3'b001,
    SelMul  = 3'b010,
    SelAnd  = 3'b011,
    SelOr   = 3'b100,
    SelNot  = 3'b101,
    SelShl1 = 3'b110,
    SelShr1 = 3'b111
  } alu_sel_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnShl1  = 6'h00;
  localparam logic [5:0] FnShr1  = 6'h02;
  localparam logic [5:0] FnMul   = 6'h18;
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnNot   = 6'h27;

  localparam int unsigned CntWidth = 16;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } issue_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Handshake/bus bundle of the ALU op issue stage.
//   upstream   : in_valid, in_ready, opcode, funct, rs_data, rt_data, imm
//   control    : flush
//   downstream : out_valid, out_ready, alu_sel, alu_a, alu_b, illegal
//   status     : issue_cnt
// Modport slave is the issue stage's view; master is the surrounding environment.
interface alu_op_issue_if;
  import alu_op_issue_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [31:0]         rs_data;
  logic [31:0]         rt_data;
  logic [15:0]         imm;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          alu_sel;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic                illegal;
  logic [CntWidth-1:0] issue_cnt;

  modport slave (
    input  in_valid, opcode, funct, rs_data, rt_data, imm, flush, out_ready,
    output in_ready, out_valid, alu_sel, alu_a, alu_b, illegal, issue_cnt
  );

  modport master (
    output in_valid, opcode, funct, rs_data, rt_data, imm, flush, out_ready,
    input  in_ready, out_valid, alu_sel, alu_a, alu_b, illegal, issue_cnt
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational op decoder: maps opcode/funct/imm/operands to ALU select and operands.
//   opcode_i, funct_i, imm_i, rs_i, rt_i : raw op fields
//   sel_o, a_o, b_o                      : ALU select and operands
//   illegal_o                            : op not recognised (sel/a/b forced to zero)
// Optional feature: define MULT_EN to decode R-type funct 0x18 as multiply;
// without it that funct is illegal.
module alu_op_decode
  import alu_op_issue_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output alu_sel_e    sel_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic        illegal_o
);

  always_comb begin
    sel_o     = SelAdd;
    a_o       = rs_i;
    b_o       = rt_i;
    illegal_o = 1'b0;

    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAdd:  sel_o = SelAdd;
          FnSub:  sel_o = SelSub;
`ifdef MULT_EN
          FnMul:  sel_o = SelMul;
`endif
          FnAnd:  sel_o = SelAnd;
          FnOr:   sel_o = SelOr;
          FnNot:  sel_o = SelNot;
          FnShl1: sel_o = SelShl1;
          FnShr1: sel_o = SelShr1;
          default: illegal_o = 1'b1;
        endcase
      end
      OpAddi, OpLw, OpSw: begin
        sel_o = SelAdd;
        b_o   = sext16(imm_i);
      end
      OpBeq:  sel_o = SelSub;
      OpAndi: begin
        sel_o = SelAnd;
        b_o   = zext16(imm_i);
      end
      OpOri: begin
        sel_o = SelOr;
        b_o   = zext16(imm_i);
      end
      default: illegal_o = 1'b1;
    endcase

    // Illegal ops still travel downstream, but carry no operand data.
    if (illegal_o) begin
      sel_o = SelAdd;
      a_o   = '0;
      b_o   = '0;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// ALU op issue stage: decodes an offered op and holds it in a single register
// stage towards the ALU with a valid/ready handshake on both sides.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_op_issue_if.slave (upstream op, flush, downstream op, issue_cnt)
// in_ready = !out_valid || out_ready, so hand-off and accept in the same cycle
// replace the held op without a bubble. flush empties the stage and beats accept.
// issue_cnt counts hand-offs (including one coinciding with flush), saturating.
// Optional feature: MULT_EN (see alu_op_decode) enables the multiply funct.
module alu_op_issue
  import alu_op_issue_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  alu_op_issue_if.slave bus
);

  alu_sel_e    dec_sel;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_illegal;

  alu_op_decode u_decode (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .imm_i     (bus.imm),
    .rs_i      (bus.rs_data),
    .rt_i      (bus.rt_data),
    .sel_o     (dec_sel),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .illegal_o (dec_illegal)
  );

  issue_state_e        state_q, state_d;
  alu_sel_e            sel_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic                illegal_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic handoff;

  assign out_valid = (state_q == StFull);
  assign in_ready  = !out_valid || bus.out_ready;
  assign accept    = bus.in_valid && in_ready && !bus.flush;
  assign handoff   = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull: begin
        if (bus.flush) begin
          state_d = StEmpty;
        end else if (handoff && !accept) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (handoff && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload only loads on accept, so it holds steady through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= SelAdd;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      sel_q     <= dec_sel;
      a_q       <= dec_a;
      b_q       <= dec_b;
      illegal_q <= dec_illegal;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.alu_sel   = sel_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.illegal   = illegal_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: a decode vector table streamed at full
// rate, then hand-written stall, flush, reset and counter-saturation sequences.
module tb_alu_op_issue;

  logic clk;
  logic rst_n = 1'b1;

  alu_op_issue_if bus ();

  alu_op_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  localparam int NVec = 16;
  vec_t vecs [NVec];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm);
    bus.opcode  = op;
    bus.funct   = fn;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.imm     = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h22, 32'd10, 32'd3, 16'h0000, 3'b001, 32'd10, 32'd3, 1'b0};
    vecs[1]  = '{6'h00, 6'h20, 32'h11111111, 32'h22222222, 16'h0, 3'b000,
                 32'h11111111, 32'h22222222, 1'b0};
    vecs[2]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 3'b011,
                 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0};
    vecs[3]  = '{6'h00, 6'h25, 32'h1, 32'h2, 16'h0, 3'b100, 32'h1, 32'h2, 1'b0};
    vecs[4]  = '{6'h00, 6'h27, 32'hA5A5A5A5, 32'h7, 16'h0, 3'b101, 32'hA5A5A5A5, 32'h7, 1'b0};
    vecs[5]  = '{6'h00, 6'h00, 32'h40, 32'h9, 16'h0, 3'b110, 32'h40, 32'h9, 1'b0};
    vecs[6]  = '{6'h00, 6'h02, 32'h80, 32'hB, 16'h0, 3'b111, 32'h80, 32'hB, 1'b0};
`ifdef MULT_EN
    vecs[7]  = '{6'h00, 6'h18, 32'd6, 32'd7, 16'h0, 3'b010, 32'd6, 32'd7, 1'b0};
`else
    vecs[7]  = '{6'h00, 6'h18, 32'd6, 32'd7, 16'h0, 3'b000, 32'd0, 32'd0, 1'b1};
`endif
    vecs[8]  = '{6'h08, 6'h00, 32'd5, 32'h33, 16'hFFFF, 3'b000, 32'd5, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{6'h0D, 6'h00, 32'h12340000, 32'h33, 16'hFFFF, 3'b100,
                 32'h12340000, 32'h0000FFFF, 1'b0};
    vecs[10] = '{6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0, 16'h8001, 3'b011,
                 32'hFFFFFFFF, 32'h00008001, 1'b0};
    vecs[11] = '{6'h23, 6'h3F, 32'h100, 32'h0, 16'h7FFF, 3'b000, 32'h100, 32'h00007FFF, 1'b0};
    vecs[12] = '{6'h2B, 6'h00, 32'h200, 32'h0, 16'h8000, 3'b000, 32'h200, 32'hFFFF8000, 1'b0};
    vecs[13] = '{6'h04, 6'h00, 32'h3, 32'hDEADBEEF, 16'h1234, 3'b001, 32'h3, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{6'h3F, 6'h20, 32'h55, 32'h66, 16'h1234, 3'b000, 32'h0, 32'h0, 1'b1};
    vecs[15] = '{6'h00, 6'h3F, 32'h77, 32'h88, 16'h0, 3'b000, 32'h0, 32'h0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_op(6'h00, 6'h20, 32'h0, 32'h0, 16'h0);

    // Reset acts without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_alu_sel",   32'(bus.alu_sel),   32'd0);
    check("reset_alu_a",     bus.alu_a,          32'd0);
    check("reset_alu_b",     bus.alu_b,          32'd0);
    check("reset_illegal",   32'(bus.illegal),   32'd0);
    check("reset_issue_cnt", 32'(bus.issue_cnt), 32'd0);
    #19 rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Decode table at full rate: each op is visible one cycle after it is offered.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      drive_op(vecs[i].opcode, vecs[i].funct, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      step();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_alu_sel", i),   32'(bus.alu_sel),   32'(vecs[i].sel));
      check($sformatf("vec%0d_alu_a", i),     bus.alu_a,          vecs[i].a);
      check($sformatf("vec%0d_alu_b", i),     bus.alu_b,          vecs[i].b);
      check($sformatf("vec%0d_illegal", i),   32'(bus.illegal),   32'(vecs[i].ill));
    end
    bus.in_valid = 1'b0;
    step();
    check("table_drained_out_valid", 32'(bus.out_valid), 32'd0);
    check("table_issue_cnt",         32'(bus.issue_cnt), 32'd16);

    // Stall: A held for 4 cycles while B waits, then A and B go back to back.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_op(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
    step();
    drive_op(6'h00, 6'h22, 32'd7, 32'd4, 16'h0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
      check($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d_alu_sel", c),   32'(bus.alu_sel),   32'd0);
      check($sformatf("stall%0d_alu_a", c),     bus.alu_a,          32'd1);
      check($sformatf("stall%0d_alu_b", c),     bus.alu_b,          32'd2);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_alu_sel",   32'(bus.alu_sel),   32'd1);
    check("b2b_alu_a",     bus.alu_a,          32'd7);
    check("b2b_alu_b",     bus.alu_b,          32'd4);
    check("b2b_issue_cnt", 32'(bus.issue_cnt), 32'd17);
    step();
    check("b2b_drained",     32'(bus.out_valid), 32'd0);
    check("b2b_issue_cnt_2", 32'(bus.issue_cnt), 32'd18);

    // Flush while FULL and stalled, with a new op offered: both discarded, no count.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_op(6'h0D, 6'h00, 32'h9, 32'h0, 16'h00F0);
    step();
    check("pre_flush_out_valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    drive_op(6'h00, 6'h24, 32'hAA, 32'hBB, 16'h0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_issue_cnt", 32'(bus.issue_cnt), 32'd18);
    step();
    check("flush_dropped_offer", 32'(bus.out_valid), 32'd0);

    // Flush coinciding with a hand-off still counts that hand-off.
    bus.in_valid = 1'b1;
    drive_op(6'h08, 6'h00, 32'h1, 32'h0, 16'h0002);
    step();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_handoff_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_handoff_issue_cnt", 32'(bus.issue_cnt), 32'd19);

    // Reset mid-stall discards the held op immediately.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_op(6'h00, 6'h25, 32'd5, 32'd6, 16'h0);
    step();
    bus.in_valid = 1'b0;
    check("mid_stall_alu_a", bus.alu_a, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_stall_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_stall_rst_alu_sel",   32'(bus.alu_sel),   32'd0);
    check("mid_stall_rst_alu_a",     bus.alu_a,          32'd0);
    check("mid_stall_rst_alu_b",     bus.alu_b,          32'd0);
    check("mid_stall_rst_issue_cnt", 32'(bus.issue_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_stall_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("mid_stall_release_empty", 32'(bus.out_valid), 32'd0);

    // Saturation: 65535 full-rate edges give 65534 hand-offs, then 3 more saturate.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_op(6'h00, 6'h20, 32'h3, 32'h4, 16'h0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_preload_cnt", 32'(bus.issue_cnt), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_cnt", 32'(bus.issue_cnt), 32'h0000FFFF);
    check("sat_out_valid", 32'(bus.out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("sat_rst_issue_cnt", 32'(bus.issue_cnt), 32'd0);
    check("sat_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("sat_rst_alu_a",     bus.alu_a,          32'd0);
    check("sat_rst_alu_b",     bus.alu_b,          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous reset, active low.
REQ-002 Upstream ports SHALL be: in_valid in 1 op offered; in_ready out 1 op accepted this cycle; opcode in 6; funct in 6; rs_data in 32; rt_data in 32; imm in 16.
REQ-003 Control input SHALL be: flush in 1 discard held op and any op offered this cycle.
REQ-004 Downstream ports SHALL be: out_valid out 1; out_ready in 1; alu_sel out 3; alu_a out 32; alu_b out 32; illegal out 1 (held op undecodable).
REQ-005 Status output SHALL be: issue_cnt out 16, the number of ops handed downstream.

Function
REQ-006 alu_sel encoding SHALL be: 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 not(a), 110 a<<1, 111 a>>1.
REQ-007 R-type (opcode 0x00) decode SHALL be: funct 0x20 add, 0x22 sub, 0x18 mul, 0x24 and, 0x25 or, 0x27 not, 0x00 shl1, 0x02 shr1; a=rs_data, b=rt_data.
REQ-008 I-type decode SHALL be: 0x08 add, 0x23 add, 0x2B add, 0x04 sub with b=rt_data; 0x0C and, 0x0D or; a=rs_data.
REQ-009 For 0x08/0x23/0x2B, b SHALL be sign-extended imm; for 0x0C/0x0D, b SHALL be zero-extended imm.
REQ-010 For 0x04 (beq), b SHALL be rt_data.
REQ-011 Any other opcode/funct SHALL register illegal=1, alu_sel=000, alu_a=0, alu_b=0.
REQ-012 Illegal ops SHALL still flow through the handshake.
REQ-013 The block SHALL be a single registered stage: in_ready = !out_valid || out_ready, combinational.
REQ-014 An op SHALL be accepted on an edge with in_valid && in_ready; decoded fields appear on outputs the next cycle (latency 1).
REQ-015 An op SHALL be handed off on an edge with out_valid && out_ready.
REQ-016 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-017 Simultaneous hand-off and accept SHALL replace the held op with no bubble.
REQ-018 flush=1 SHALL clear out_valid at the next edge and drop any op offered that cycle; flush has priority over accept.
REQ-019 A hand-off coinciding with flush SHALL still count.
REQ-020 issue_cnt SHALL increment by 1 per hand-off and saturate at 0xFFFF.
REQ-021 The block SHALL have no states beyond EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-022 EMPTY SHALL go to FULL on accept; FULL SHALL go to EMPTY on hand-off without accept, or on flush.

Reset
REQ-023 rst_n=0 SHALL immediately force out_valid=0, alu_sel=000, alu_a=0, alu_b=0, illegal=0, issue_cnt=0, independent of clk.
REQ-024 Reset asserted mid-stall SHALL discard the held op.
REQ-025 After rst_n rises, in_ready=1.

Configuration
REQ-026 With MULT_EN defined, funct 0x18 SHALL decode to alu_sel=010.
REQ-027 Without MULT_EN, funct 0x18 SHALL decode as illegal per REQ-011.

Structure
REQ-028 The shared package SHALL hold the alu_sel encodings, opcode/funct constants and the 16-bit counter width.
REQ-029 One combinational sub-module, alu_op_decode, SHALL map opcode/funct/imm/operands to sel/a/b/illegal; alu_op_issue adds the register stage, handshake, flush and counter.

Verification
REQ-030 Bench: opcode 0x00, funct 0x22, rs=10, rt=3, out_ready=1 -> next cycle out_valid=1, alu_sel=001, a=10, b=3, illegal=0; issue_cnt=1 after hand-off.
REQ-031 Bench: addi imm=0xFFFF, rs=5 -> b=0xFFFFFFFF, sel=000; ori imm=0xFFFF -> b=0x0000FFFF, sel=100.
REQ-032 Bench: hold out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs stable; raise out_ready -> back-to-back hand-offs, no bubble, no loss.
REQ-033 Bench: flush with in_valid=1 while FULL and out_ready=0 -> out_valid=0 next cycle, issue_cnt unchanged.
REQ-034 Bench: funct 0x18 -> sel=010 with MULT_EN, illegal=1 without; opcode 0x3F -> illegal=1, a=b=0.
REQ-035 Bench: preload issue_cnt to 0xFFFE, perform 3 hand-offs -> 0xFFFF; assert rst_n low between edges -> outputs 0 immediately.
